// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-wide memory bus unit: FSM states, bus
// direction encoding and the default idle address.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // 6502 polarity on bus_rw
    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    localparam logic [15:0] RESET_ADDR_DEFAULT = 16'hFFFC;

endpackage

// File: rtl/mem_bus_unit.sv
// Splits 8/16-bit core accesses into little-endian byte cycles on an 8-bit bus.
// Define BUS_WAIT_EN to add the bus_ready port and honour wait states.
module mem_bus_unit
    import mem_bus_pkg::*;
#(
    parameter logic [15:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_word,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_en,
    output logic        bus_rw,
    output logic [7:0]  bus_dout,
`ifdef BUS_WAIT_EN
    input  logic        bus_ready,
`endif
    input  logic [7:0]  bus_din
);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        word_q, word_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic        bus_en_q, bus_en_d;
    logic        bus_rw_q, bus_rw_d;
    logic [7:0]  bus_dout_q, bus_dout_d;

    logic        bus_done;

`ifdef BUS_WAIT_EN
    assign bus_done = bus_ready;
`else
    assign bus_done = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            word_q      <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            bus_addr_q  <= RESET_ADDR;
            bus_en_q    <= 1'b0;
            bus_rw_q    <= BUS_READ;
            bus_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_addr_q  <= bus_addr_d;
            bus_en_q    <= bus_en_d;
            bus_rw_q    <= bus_rw_d;
            bus_dout_q  <= bus_dout_d;
        end
    end

    // Next state plus capture of the request and of returned read bytes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_LO;
                    addr_d  = req_addr;
                    we_d    = req_we;
                    word_d  = req_word;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                end
            end
            ST_LO: begin
                if (bus_done) begin
                    state_d = word_q ? ST_HI : ST_RESP;
                    if (!we_q) rdata_d = {8'h00, bus_din};
                end
            end
            ST_HI: begin
                if (bus_done) begin
                    state_d = ST_RESP;
                    if (!we_q) rdata_d = {bus_din, rdata_q[7:0]};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so every port comes from a flop.
    always_comb begin
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        bus_addr_d  = RESET_ADDR;
        bus_en_d    = 1'b0;
        bus_rw_d    = BUS_READ;
        bus_dout_d  = '0;
        case (state_d)
            ST_IDLE: req_ready_d = 1'b1;
            ST_LO: begin
                bus_en_d   = 1'b1;
                bus_rw_d   = we_d ? BUS_WRITE : BUS_READ;
                bus_addr_d = addr_d;
                bus_dout_d = wdata_d[7:0];
            end
            ST_HI: begin
                bus_en_d   = 1'b1;
                bus_rw_d   = we_d ? BUS_WRITE : BUS_READ;
                bus_addr_d = addr_d + 16'd1;
                bus_dout_d = wdata_d[15:8];
            end
            default: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rdata_d;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_en    = bus_en_q;
    assign bus_rw    = bus_rw_q;
    assign bus_dout  = bus_dout_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Self-checking bench for mem_bus_unit: per-cycle expected-output queue driven
// by a transaction-level model, plus directed literal checks.
module tb_mem_bus_unit;
    import mem_bus_pkg::*;

    localparam logic [15:0] RADDR = 16'hFFFC;
    localparam logic [1:0] K_IDLE = 2'd0;
    localparam logic [1:0] K_BUS  = 2'd1;
    localparam logic [1:0] K_RESP = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_word;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid;
    logic [15:0] rsp_rdata, bus_addr;
    logic        bus_en, bus_rw;
    logic [7:0]  bus_dout, bus_din;
    logic        bus_ready;

    logic [7:0]  rom [0:65535];
    exp_t        exp_q[$];
    exp_t        cur_e, pop_e;
    int          checks = 0;
    int          errors = 0;

    logic [15:0] obs_addr [0:7];
    logic [7:0]  obs_dout [0:7];
    logic        obs_en   [0:7];
    logic        obs_rw   [0:7];
    logic        obs_rv   [0:7];
    logic [15:0] obs_rd   [0:7];

    always #5 clk = ~clk;

    assign bus_din = rom[bus_addr];

    mem_bus_unit #(.RESET_ADDR(RADDR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_word  (req_word),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bus_addr  (bus_addr),
        .bus_en    (bus_en),
        .bus_rw    (bus_rw),
        .bus_dout  (bus_dout),
`ifdef BUS_WAIT_EN
        .bus_ready (bus_ready),
`endif
        .bus_din   (bus_din)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Transaction model: an accepted request expands into one record per cycle.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (!(exp_q[0].kind == K_BUS && !bus_ready)) pop_e = exp_q.pop_front();
        end else if (req_valid) begin
            logic [15:0] a1;
            logic [15:0] rd;
            a1 = req_addr + 16'd1;
            if (req_we)        rd = 16'h0000;
            else if (req_word) rd = {rom[a1], rom[req_addr]};
            else               rd = {8'h00, rom[req_addr]};
            exp_q.push_back('{K_BUS, ~req_we, req_addr, req_wdata[7:0], 16'h0});
            if (req_word) exp_q.push_back('{K_BUS, ~req_we, a1, req_wdata[15:8], 16'h0});
            exp_q.push_back('{K_RESP, 1'b1, 16'h0, 8'h0, rd});
        end
    end

    // Compare process: every cycle, DUT outputs against the model's record.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_ready", 32'(req_ready), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
            check("rst_bus_en",    32'(bus_en),    32'd0);
            check("rst_bus_rw",    32'(bus_rw),    32'd1);
            check("rst_bus_dout",  32'(bus_dout),  32'd0);
            check("rst_bus_addr",  32'(bus_addr),  32'(RADDR));
        end else begin
            cur_e = (exp_q.size() != 0) ? exp_q[0] : '{K_IDLE, 1'b1, RADDR, 8'h0, 16'h0};
            check("req_ready", 32'(req_ready), 32'(cur_e.kind == K_IDLE));
            check("bus_en",    32'(bus_en),    32'(cur_e.kind == K_BUS));
            check("rsp_valid", 32'(rsp_valid), 32'(cur_e.kind == K_RESP));
            if (cur_e.kind != K_RESP) begin
                check("bus_addr", 32'(bus_addr), 32'(cur_e.addr));
                check("bus_rw",   32'(bus_rw),   32'(cur_e.rw));
            end
            if (cur_e.kind == K_BUS) check("bus_dout", 32'(bus_dout), 32'(cur_e.dout));
            if (cur_e.kind == K_RESP) check("rsp_rdata", 32'(rsp_rdata), 32'(cur_e.rdata));
        end
    end

    // Waits for an idle model, presents one request, returns just after the accept edge.
    task automatic issue(input logic we, input logic word, input logic [15:0] addr, input logic [15:0] wd);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'(n), 32'd0);
        req_valid = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Samples cycles 1..n after the accept edge; raises bus_ready in cycle rel.
    task automatic observe(input int n, input int rel);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk); #1;
            if (i == rel) bus_ready = 1'b1;
            obs_addr[i] = bus_addr; obs_dout[i] = bus_dout; obs_en[i] = bus_en;
            obs_rw[i] = bus_rw; obs_rv[i] = rsp_valid; obs_rd[i] = rsp_rdata;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[16'h1234] = 8'hCD; rom[16'h1235] = 8'hAB;
        rom[16'hFFFF] = 8'h11; rom[16'h0000] = 8'h22;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; bus_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Word read at 1234: bytes CD then AB, response three cycles after accept.
        issue(1'b0, 1'b1, 16'h1234, 16'h0);
        observe(3, 0);
        check("w_rd_addr_lo", 32'(obs_addr[1]), 32'h1234);
        check("w_rd_addr_hi", 32'(obs_addr[2]), 32'h1235);
        check("w_rd_no_early", 32'(obs_rv[2]), 32'd0);
        check("w_rd_rv", 32'(obs_rv[3]), 32'd1);
        check("w_rd_data", 32'(obs_rd[3]), 32'hABCD);

        // Byte write of 5A77 to 0200.
        issue(1'b1, 1'b0, 16'h0200, 16'h5A77);
        observe(2, 0);
        check("b_wr_en", 32'(obs_en[1]), 32'd1);
        check("b_wr_rw", 32'(obs_rw[1]), 32'd0);
        check("b_wr_dout", 32'(obs_dout[1]), 32'h77);
        check("b_wr_rv", 32'(obs_rv[2]), 32'd1);
        check("b_wr_rdata", 32'(obs_rd[2]), 32'h0);

        // Word read wrapping from FFFF to 0000.
        issue(1'b0, 1'b1, 16'hFFFF, 16'h0);
        observe(3, 0);
        check("wrap_addr", 32'(obs_addr[2]), 32'h0000);
        check("wrap_data", 32'(obs_rd[3]), 32'h2211);

        // Byte read zero-fills the upper byte.
        issue(1'b0, 1'b0, 16'h1235, 16'hFFFF);
        observe(2, 0);
        check("b_rd_data", 32'(obs_rd[2]), 32'h00AB);

`ifdef BUS_WAIT_EN
        // Three wait cycles on the low byte of a word write.
        issue(1'b1, 1'b1, 16'h3000, 16'hBEEF);
        bus_ready = 1'b0;
        observe(6, 4);
        for (int i = 1; i <= 4; i++) begin
            check("ws_addr", 32'(obs_addr[i]), 32'h3000);
            check("ws_dout", 32'(obs_dout[i]), 32'hEF);
        end
        check("ws_hi_addr", 32'(obs_addr[5]), 32'h3001);
        check("ws_no_early", 32'(obs_rv[5]), 32'd0);
        check("ws_rv", 32'(obs_rv[6]), 32'd1);
`endif

        // Reset while the high byte of a word read is on the bus.
        issue(1'b0, 1'b1, 16'h4000, 16'h0);
        @(posedge clk); #2;
        check("pre_rst_hi", 32'(bus_addr), 32'h4001);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_bus_en", 32'(bus_en), 32'd0);
        check("arst_bus_addr", 32'(bus_addr), 32'(RADDR));
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk); #1 rst = 1'b0;
        observe(4, 0);
        for (int i = 1; i <= 4; i++) check("arst_no_rsp", 32'(obs_rv[i]), 32'd0);
        issue(1'b0, 1'b0, 16'h1234, 16'h0);
        observe(2, 0);
        check("post_rst_data", 32'(obs_rd[2]), 32'h00CD);

        // Random traffic, then req_valid held high continuously.
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            req_valid = (c >= 380) ? 1'b1 : ($urandom_range(0, 2) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_word  = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            req_wdata = 16'($urandom);
`ifdef BUS_WAIT_EN
            bus_ready = ($urandom_range(0, 3) != 0);
`endif
        end
        req_valid = 1'b0;
        bus_ready = 1'b1;
        repeat (10) @(posedge clk);
        check("drain_idle", 32'(exp_q.size()), 32'd0);
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
